// File: rtl/dec_issue_buffer_if.sv
// Interface for the issue buffer: fetch-side push lanes, issue-side slots,
// flush and occupancy. The buffer connects through the slave modport and the
// fetch/issue environment through the master modport.
interface dec_issue_buffer_if #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    flush;
  logic [FETCH_W-1:0]      push_valid;
  logic [32*FETCH_W-1:0]   push_instr;
  logic [32*FETCH_W-1:0]   push_pc;
  logic                    push_ready;
  logic                    issue_ready;
  logic [ISSUE_W-1:0]      issue_valid;
  logic [32*ISSUE_W-1:0]   issue_instr;
  logic [32*ISSUE_W-1:0]   issue_pc;
  logic [ISSUE_W-1:0]      issue_ri;
  logic [CW-1:0]           count;

  modport master (
    output flush, push_valid, push_instr, push_pc, issue_ready,
    input  push_ready, issue_valid, issue_instr, issue_pc, issue_ri, count
  );

  modport slave (
    input  flush, push_valid, push_instr, push_pc, issue_ready,
    output push_ready, issue_valid, issue_instr, issue_pc, issue_ri, count
  );
endinterface

// File: rtl/dec_issue_buffer.sv
// Multi-issue instruction buffer: circular FIFO of fetched MIPS32 words with
// pre-decode of the head entries and in-order selection of the largest group
// that can issue together (structural, control and register hazards).
module dec_issue_buffer #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  dec_issue_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       mem;
    logic       muldiv;
    logic       branch;
    logic       solo;
    logic       ri;
    logic [4:0] dest;   // 0 means no destination
    logic [4:0] rs;
    logic [4:0] rt;
  } pd_t;

  // Classify one instruction from its fields; unknown encodings become ri+solo.
  function automatic pd_t predecode(input logic [5:0] op, input logic [5:0] fn,
                                    input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd);
    pd_t d;
    d    = '0;
    d.rs = rs;
    d.rt = rt;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0A, 6'h0B,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B:                          d.dest = rd;
          6'h08:                                 d.branch = 1'b1;
          6'h09: begin d.branch = 1'b1; d.dest = rd; end
          6'h0C, 6'h0D:                          d.solo = 1'b1;
          6'h10, 6'h12: begin d.muldiv = 1'b1; d.dest = rd; end
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: d.muldiv = 1'b1;
          6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h36: d.solo = 1'b1;
          default:                               d.ri = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01:                          d.branch = 1'b1;
          5'h10, 5'h11: begin d.branch = 1'b1; d.dest = 5'd31; end
          5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0E: d.solo = 1'b1;
          default:                               d.ri = 1'b1;
        endcase
      end
      6'h02, 6'h04, 6'h05, 6'h06, 6'h07:         d.branch = 1'b1;
      6'h03: begin d.branch = 1'b1; d.dest = 5'd31; end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: d.dest = rt;
      6'h10: begin
        case (rs)
          5'h00: begin d.solo = 1'b1; d.dest = rt; end
          5'h04:                                 d.solo = 1'b1;
          5'h10: begin
            d.solo = (fn == 6'h18);
            d.ri   = (fn != 6'h18);
          end
          default:                               d.ri = 1'b1;
        endcase
      end
      6'h1C: begin
        case (fn)
          6'h00, 6'h01, 6'h04, 6'h05:            d.muldiv = 1'b1;
          6'h02: begin d.muldiv = 1'b1; d.dest = rd; end
          6'h20, 6'h21:                          d.dest = rd;
          default:                               d.ri = 1'b1;
        endcase
      end
      6'h1F: begin
        case (fn)
          6'h00, 6'h04:                          d.dest = rt;
          default:                               d.ri = 1'b1;
        endcase
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h30: begin
        d.mem  = 1'b1;
        d.dest = rt;
      end
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E:         d.mem = 1'b1;
      default:                                   d.ri = 1'b1;
    endcase
    d.solo = d.solo | d.ri;
    if (d.ri) begin
      d.dest = 5'd0;
    end else begin
      d.dest = d.dest;
    end
    return d;
  endfunction

  logic [31:0]        instr_mem_r [DEPTH];
  logic [31:0]        pc_mem_r    [DEPTH];
  logic [AW-1:0]      rd_ptr_r;
  logic [AW-1:0]      wr_ptr_r;
  logic [CW-1:0]      count_r;
  logic               push_ready_s;
  logic [CW-1:0]      push_n_s;
  logic [CW-1:0]      pop_n_s;
  logic [ISSUE_W-1:0] valid_s;
  pd_t                pd_s        [ISSUE_W];
  logic [31:0]        head_instr_s[ISSUE_W];
  logic [31:0]        head_pc_s   [ISSUE_W];

  // Room for a full fetch group, judged on the registered count only.
  assign push_ready_s = (count_r <= CW'(DEPTH - FETCH_W));

  // Number of accepted lanes: the leading run of valid lanes from lane 0.
  always_comb begin
    logic run;
    run      = 1'b1;
    push_n_s = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      run      = run & bus.push_valid[k];
      push_n_s = push_n_s + CW'(run);
    end
    if (!push_ready_s || bus.flush) begin
      push_n_s = '0;
    end else begin
      push_n_s = push_n_s;
    end
  end

  // Read the head window and pre-decode each entry.
  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      head_instr_s[i] = instr_mem_r[rd_ptr_r + AW'(i)];
      head_pc_s[i]    = pc_mem_r[rd_ptr_r + AW'(i)];
      pd_s[i]         = predecode(head_instr_s[i][31:26], head_instr_s[i][5:0],
                                  head_instr_s[i][25:21], head_instr_s[i][20:16],
                                  head_instr_s[i][15:11]);
    end
  end

  // Grow the issue group slot by slot while no pairing rule is violated.
  always_comb begin
    logic ok;
    ok         = 1'b0;
    valid_s    = '0;
    valid_s[0] = (count_r != '0);
    for (int k = 1; k < ISSUE_W; k++) begin
      ok = valid_s[k-1] && (count_r > CW'(k)) && !pd_s[k].branch && !pd_s[k].solo;
      for (int j = 0; j < k; j++) begin
        ok = ok && !(pd_s[j].mem && pd_s[k].mem)
                && !(pd_s[j].muldiv && pd_s[k].muldiv)
                && !pd_s[j].solo
                && !((pd_s[j].dest != 5'd0) &&
                     ((pd_s[j].dest == pd_s[k].rs) ||
                      (pd_s[j].dest == pd_s[k].rt) ||
                      (pd_s[j].dest == pd_s[k].dest)));
      end
      valid_s[k] = ok;
    end
  end

  // Entries leaving this cycle: the whole presented group when accepted.
  always_comb begin
    pop_n_s = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      pop_n_s = pop_n_s + CW'(valid_s[i]);
    end
    if (!bus.issue_ready || bus.flush) begin
      pop_n_s = '0;
    end else begin
      pop_n_s = pop_n_s;
    end
  end

  // Pointer and occupancy update; flush empties the buffer and wins over push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (bus.flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_r + pop_n_s[AW-1:0];
      wr_ptr_r <= wr_ptr_r + push_n_s[AW-1:0];
      count_r  <= count_r + push_n_s - pop_n_s;
    end
  end

  // Payload storage (not reset): write the accepted lanes at the tail.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (CW'(k) < push_n_s) begin
        instr_mem_r[wr_ptr_r + AW'(k)] <= bus.push_instr[32*k +: 32];
        pc_mem_r[wr_ptr_r + AW'(k)]    <= bus.push_pc[32*k +: 32];
      end
    end
  end

  // Drive the issue slots from the head window; ri only flags issuing slots.
  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      bus.issue_instr[32*i +: 32] = head_instr_s[i];
      bus.issue_pc[32*i +: 32]    = head_pc_s[i];
      bus.issue_ri[i]             = valid_s[i] & pd_s[i].ri;
    end
  end

  assign bus.push_ready  = push_ready_s;
  assign bus.issue_valid = valid_s;
  assign bus.count       = count_r;
endmodule

// File: tb/tb_dec_issue_buffer.sv
// Self-checking bench for dec_issue_buffer: directed scenarios plus a random
// stream checked against a queue model with a mnemonic attribute table.
module tb_dec_issue_buffer;
  localparam int DEPTH   = 8;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int NPOOL   = 20;

  typedef struct {
    logic [31:0] tmpl;
    logic [31:0] mask;
    bit          mem;
    bit          md;
    bit          br;
    bit          solo;
    bit          ri;
    int          dk;   // 0 none, 1 rd, 2 rt, 3 r31
  } op_t;

  logic        clk = 1'b0;
  logic        resetn;
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] pc_ctr  = 32'h0000_1000;
  logic [31:0] m_instr[$];
  logic [31:0] m_pc[$];
  op_t         pool[NPOOL];

  dec_issue_buffer_if #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) bus ();

  dec_issue_buffer #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic init_pool();
    pool[0]  = '{32'h00000021, 32'hFC00003F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // ADDU
    pool[1]  = '{32'h34000000, 32'hFC000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2}; // ORI
    pool[2]  = '{32'h24000000, 32'hFC000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2}; // ADDIU
    pool[3]  = '{32'h8C000000, 32'hFC000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2}; // LW
    pool[4]  = '{32'hAC000000, 32'hFC000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0}; // SW
    pool[5]  = '{32'h80000000, 32'hFC000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2}; // LB
    pool[6]  = '{32'h00000018, 32'hFC00003F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0}; // MULT
    pool[7]  = '{32'h00000012, 32'hFC00003F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1}; // MFLO
    pool[8]  = '{32'h70000002, 32'hFC00003F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1}; // MUL
    pool[9]  = '{32'h10000000, 32'hFC000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // BEQ
    pool[10] = '{32'h0C000000, 32'hFC000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3}; // JAL
    pool[11] = '{32'h00000008, 32'hFC00003F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // JR
    pool[12] = '{32'h04110000, 32'hFC1F0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3}; // BGEZAL
    pool[13] = '{32'h0000000C, 32'hFC00003F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0}; // SYSCALL
    pool[14] = '{32'h40000000, 32'hFFE007FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2}; // MFC0
    pool[15] = '{32'hFC000000, 32'hFC000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0}; // reserved
    pool[16] = '{32'h70000020, 32'hFC00003F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // CLZ
    pool[17] = '{32'h00000034, 32'hFC00003F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0}; // TEQ
    pool[18] = '{32'h7C000000, 32'hFC00003F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2}; // EXT
    pool[19] = '{32'h00000000, 32'hFC00003F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // SLL
  endtask

  function automatic op_t classify(input logic [31:0] ins);
    op_t r;
    bit  found;
    r     = pool[15];
    found = 1'b0;
    for (int i = 0; i < NPOOL; i++) begin
      if (!found && ((ins & pool[i].mask) == pool[i].tmpl)) begin
        r     = pool[i];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic int dest_of(input op_t a, input logic [31:0] ins);
    case (a.dk)
      1:       return int'(ins[15:11]);
      2:       return int'(ins[20:16]);
      3:       return 31;
      default: return 0;
    endcase
  endfunction

  // Size of the group the model's head would issue under the pairing rules.
  function automatic int exp_group();
    op_t         a0, a1;
    int          d0, d1;
    logic [31:0] x0, x1;
    if (m_instr.size() == 0) return 0;
    if (m_instr.size() == 1) return 1;
    x0 = m_instr[0];
    x1 = m_instr[1];
    a0 = classify(x0);
    a1 = classify(x1);
    d0 = dest_of(a0, x0);
    d1 = dest_of(a1, x1);
    if (a1.br || a1.solo || a0.solo) return 1;
    if (a0.mem && a1.mem) return 1;
    if (a0.md && a1.md) return 1;
    if (d0 != 0 && (d0 == int'(x1[25:21]) || d0 == int'(x1[20:16]) || d0 == d1)) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] rand_instr();
    op_t p;
    p = pool[$urandom_range(NPOOL-1, 0)];
    return p.tmpl | ($urandom & ~p.mask & 32'h00E73800);
  endfunction

  // Drive one cycle of inputs, advance the model, then step past the edge.
  task automatic cycle(input bit fl, input logic [1:0] pv, input logic [31:0] i0,
                       input logic [31:0] i1, input bit ir);
    int g;
    int c;
    bus.flush       = fl;
    bus.push_valid  = pv;
    bus.push_instr  = {i1, i0};
    bus.push_pc     = {pc_ctr + 32'd4, pc_ctr};
    bus.issue_ready = ir;
    g = exp_group();
    c = m_instr.size();
    if (fl) begin
      m_instr.delete();
      m_pc.delete();
    end else begin
      if (ir) begin
        for (int n = 0; n < g; n++) begin
          void'(m_instr.pop_front());
          void'(m_pc.pop_front());
        end
      end
      if (c <= DEPTH - FETCH_W && pv[0]) begin
        m_instr.push_back(i0);
        m_pc.push_back(pc_ctr);
        if (pv[1]) begin
          m_instr.push_back(i1);
          m_pc.push_back(pc_ctr + 32'd4);
        end
      end
    end
    pc_ctr = pc_ctr + 32'd8;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn          = 1'b0;
    bus.flush       = 1'b0;
    bus.push_valid  = '0;
    bus.push_instr  = '0;
    bus.push_pc     = '0;
    bus.issue_ready = 1'b0;
    m_instr.delete();
    m_pc.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 4;
    if (bus.count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    if (bus.issue_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", bus.issue_valid); end
    if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b want 1", bus.push_ready); end
    if (bus.issue_ri !== 2'b00) begin errors++; $display("FAIL reset_ri got %b want 00", bus.issue_ri); end
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_dual_issue();
    cycle(1'b0, 2'b11, 32'h00221821, 32'h34850001, 1'b0);
    vectors += 3;
    if (bus.count !== 4'd2) begin errors++; $display("FAIL dual_count got %0d want 2", bus.count); end
    if (bus.issue_valid !== 2'b11) begin errors++; $display("FAIL dual_valid got %b want 11", bus.issue_valid); end
    if (bus.issue_instr[63:32] !== 32'h34850001) begin errors++; $display("FAIL dual_slot1 got %h want 34850001", bus.issue_instr[63:32]); end
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    vectors += 2;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL dual_pop_count got %0d want 0", bus.count); end
    if (bus.issue_valid !== 2'b00) begin errors++; $display("FAIL dual_pop_valid got %b want 00", bus.issue_valid); end
  endtask

  task automatic test_raw_hazard();
    cycle(1'b0, 2'b11, 32'h24020005, 32'h00421821, 1'b0);
    vectors += 2;
    if (bus.issue_valid !== 2'b01) begin errors++; $display("FAIL raw_valid got %b want 01", bus.issue_valid); end
    if (bus.issue_instr[31:0] !== 32'h24020005) begin errors++; $display("FAIL raw_slot0 got %h want 24020005", bus.issue_instr[31:0]); end
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    vectors += 3;
    if (bus.issue_valid !== 2'b01) begin errors++; $display("FAIL raw2_valid got %b want 01", bus.issue_valid); end
    if (bus.issue_instr[31:0] !== 32'h00421821) begin errors++; $display("FAIL raw2_slot0 got %h want 00421821", bus.issue_instr[31:0]); end
    if (bus.count !== 4'd1) begin errors++; $display("FAIL raw2_count got %0d want 1", bus.count); end
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_mem_and_branch();
    cycle(1'b0, 2'b11, 32'h8C410000, 32'h8C430004, 1'b0);
    vectors += 1;
    if (bus.issue_valid !== 2'b01) begin errors++; $display("FAIL lw_valid got %b want 01", bus.issue_valid); end
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    vectors += 2;
    if (bus.issue_valid !== 2'b01) begin errors++; $display("FAIL lw2_valid got %b want 01", bus.issue_valid); end
    if (bus.issue_instr[31:0] !== 32'h8C430004) begin errors++; $display("FAIL lw2_slot0 got %h want 8c430004", bus.issue_instr[31:0]); end
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 2'b11, 32'h10220003, 32'h00000000, 1'b0);
    vectors += 1;
    if (bus.issue_valid !== 2'b11) begin errors++; $display("FAIL delay_slot_valid got %b want 11", bus.issue_valid); end
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_reserved();
    cycle(1'b0, 2'b11, 32'hFC000000, 32'h00221821, 1'b0);
    vectors += 2;
    if (bus.issue_valid !== 2'b01) begin errors++; $display("FAIL ri_valid got %b want 01", bus.issue_valid); end
    if (bus.issue_ri !== 2'b01) begin errors++; $display("FAIL ri_flag got %b want 01", bus.issue_ri); end
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    vectors += 1;
    if (bus.issue_ri !== 2'b00) begin errors++; $display("FAIL ri_next got %b want 00", bus.issue_ri); end
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_full();
    logic [31:0] head_pc;
    head_pc = pc_ctr;
    for (int n = 0; n < 3; n++) cycle(1'b0, 2'b11, 32'h00221821, 32'h34850001, 1'b0);
    vectors += 2;
    if (bus.count !== 4'd6) begin errors++; $display("FAIL fill_count got %0d want 6", bus.count); end
    if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL fill6_ready got %b want 1", bus.push_ready); end
    cycle(1'b0, 2'b01, 32'h00221821, 32'h34850001, 1'b0);
    vectors += 2;
    if (bus.count !== 4'd7) begin errors++; $display("FAIL fill7_count got %0d want 7", bus.count); end
    if (bus.push_ready !== 1'b0) begin errors++; $display("FAIL fill7_ready got %b want 0", bus.push_ready); end
    cycle(1'b0, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0);
    vectors += 2;
    if (bus.count !== 4'd7) begin errors++; $display("FAIL full_drop_count got %0d want 7", bus.count); end
    if (bus.issue_pc[31:0] !== head_pc) begin errors++; $display("FAIL full_head_pc got %h want %h", bus.issue_pc[31:0], head_pc); end
  endtask

  task automatic test_stream();
    int g;
    for (int n = 0; n < 20; n++) begin
      g = exp_group();
      vectors += 1;
      if (bus.count !== CW'(m_instr.size())) begin errors++; $display("FAIL stream_count got %0d want %0d", bus.count, m_instr.size()); end
      for (int s = 0; s < g; s++) begin
        vectors += 1;
        if (bus.issue_pc[32*s +: 32] !== m_pc[s]) begin errors++; $display("FAIL stream_pc slot %0d got %h want %h", s, bus.issue_pc[32*s +: 32], m_pc[s]); end
      end
      cycle(1'b0, 2'b11, 32'h00221821, 32'h34850001, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    for (int n = 0; n < 3; n++) cycle(1'b0, 2'b11, 32'h00000000, 32'h00000000, 1'b0);
    vectors += 2;
    if (bus.count !== 4'd6) begin errors++; $display("FAIL b2b_pre_count got %0d want 6", bus.count); end
    if (bus.issue_valid !== 2'b11) begin errors++; $display("FAIL b2b_pre_valid got %b want 11", bus.issue_valid); end
    cycle(1'b0, 2'b11, 32'h00000000, 32'h00000000, 1'b1);
    vectors += 2;
    if (bus.count !== 4'd6) begin errors++; $display("FAIL b2b_count got %0d want 6", bus.count); end
    if (bus.issue_pc[31:0] !== m_pc[0]) begin errors++; $display("FAIL b2b_head_pc got %h want %h", bus.issue_pc[31:0], m_pc[0]); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 2'b00, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 2'b11, 32'h00221821, 32'h34850001, 1'b0);
    cycle(1'b0, 2'b11, 32'h00221821, 32'h34850001, 1'b0);
    cycle(1'b0, 2'b01, 32'h00221821, 32'h34850001, 1'b0);
    vectors += 1;
    if (bus.count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got %0d want 5", bus.count); end
    cycle(1'b1, 2'b11, 32'h00221821, 32'h34850001, 1'b1);
    vectors += 2;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.count); end
    if (bus.issue_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b want 00", bus.issue_valid); end
    cycle(1'b0, 2'b11, 32'h00221821, 32'h34850001, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    vectors += 2;
    if (bus.count !== '0) begin errors++; $display("FAIL async_reset_count got %0d want 0", bus.count); end
    if (bus.issue_valid !== 2'b00) begin errors++; $display("FAIL async_reset_valid got %b want 00", bus.issue_valid); end
    do_reset();
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int          g;
    logic [1:0]  exp_v;
    bit          exp_ri;
    for (int n = 0; n < 400; n++) begin
      g     = exp_group();
      exp_v = (g == 2) ? 2'b11 : ((g == 1) ? 2'b01 : 2'b00);
      vectors += 3;
      if (bus.count !== CW'(m_instr.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", n, bus.count, m_instr.size()); end
      if (bus.push_ready !== (m_instr.size() <= DEPTH - FETCH_W)) begin errors++; $display("FAIL rnd_push_ready cyc %0d got %b", n, bus.push_ready); end
      if (bus.issue_valid !== exp_v) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", n, bus.issue_valid, exp_v); end
      for (int s = 0; s < ISSUE_W; s++) begin
        exp_ri = (s < g) ? classify(m_instr[s]).ri : 1'b0;
        vectors += 1;
        if (bus.issue_ri[s] !== exp_ri) begin errors++; $display("FAIL rnd_ri cyc %0d slot %0d got %b want %b", n, s, bus.issue_ri[s], exp_ri); end
        if (s < g) begin
          vectors += 2;
          if (bus.issue_instr[32*s +: 32] !== m_instr[s]) begin errors++; $display("FAIL rnd_instr cyc %0d slot %0d got %h want %h", n, s, bus.issue_instr[32*s +: 32], m_instr[s]); end
          if (bus.issue_pc[32*s +: 32] !== m_pc[s]) begin errors++; $display("FAIL rnd_pc cyc %0d slot %0d got %h want %h", n, s, bus.issue_pc[32*s +: 32], m_pc[s]); end
        end
      end
      cycle($urandom_range(39, 0) == 0, 2'($urandom_range(3, 0)), rand_instr(), rand_instr(),
            $urandom_range(3, 0) != 0);
    end
  endtask

  initial begin
    init_pool();
    test_reset();
    test_dual_issue();
    test_raw_hazard();
    test_mem_and_branch();
    test_reserved();
    test_full();
    test_stream();
    test_back_to_back();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
